// File: rtl/axil_to_mem_bridge.sv
// ---------------------------------------------------------------------------
// axil_to_mem_bridge
//
// AXI4-Lite subordinate that forwards each write/read transaction to a simple
// single-cycle register interface (mem_we/mem_waddr/mem_re/mem_raddr), as
// exposed by UART and other peripheral register blocks. The peripheral answers
// combinationally in the same cycle the enable is high.
//
// Write and read paths are independent three-state FSMs (IDLE/EXEC/RESP) and
// may both issue to the memory side in the same cycle. Each AXI transaction
// produces exactly one enable pulse, so destructive reads (FIFO pops) happen
// once even when the R channel is back-pressured.
//
// Ports:
//   clk_i, arst_ni          clock, asynchronous active-low reset
//   s_aw* / s_w* / s_b*     AXI4-Lite write address, data, response channels
//   s_ar* / s_r*            AXI4-Lite read address, data channels
//   mem_we_o, mem_waddr_o,
//   mem_wdata_o, mem_wstrb_o,
//   mem_wresp_i             memory-side write port (response same cycle)
//   mem_re_o, mem_raddr_o,
//   mem_rdata_i, mem_rresp_i memory-side read port (data same cycle)
// ---------------------------------------------------------------------------
module axil_to_mem_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      arst_ni,
  input  logic                      clk_i,
  // AXI4-Lite write address channel
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic                      s_awvalid_i,
  output logic                      s_awready_o,
  // AXI4-Lite write data channel
  input  logic [DATA_WIDTH-1:0]     s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb_i,
  input  logic                      s_wvalid_i,
  output logic                      s_wready_o,
  // AXI4-Lite write response channel
  output logic [1:0]                s_bresp_o,
  output logic                      s_bvalid_o,
  input  logic                      s_bready_i,
  // AXI4-Lite read address channel
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr_i,
  input  logic                      s_arvalid_i,
  output logic                      s_arready_o,
  // AXI4-Lite read data channel
  output logic [DATA_WIDTH-1:0]     s_rdata_o,
  output logic [1:0]                s_rresp_o,
  output logic                      s_rvalid_o,
  input  logic                      s_rready_i,
  // Memory-side write port
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_waddr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb_o,
  input  logic [1:0]                mem_wresp_i,
  // Memory-side read port
  output logic                      mem_re_o,
  output logic [ADDR_WIDTH-1:0]     mem_raddr_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  input  logic [1:0]                mem_rresp_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_EXEC = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_EXEC = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  // -------------------------------------------------------------------------
  // Write path state
  // -------------------------------------------------------------------------
  w_state_e                w_state_q, w_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q,  w_held_d;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [1:0]              bresp_q;
  logic                    aw_hs;
  logic                    w_hs;

  // -------------------------------------------------------------------------
  // Read path state
  // -------------------------------------------------------------------------
  r_state_e                r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              rresp_q;
  logic                    ar_hs;

  // Address bits above ADDR_WIDTH carry no meaning for the peripheral; no
  // decode error is raised for them.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr_i[AXI_ADDR_WIDTH-1:ADDR_WIDTH],
                              s_araddr_i[AXI_ADDR_WIDTH-1:ADDR_WIDTH]};

  // Readies are gated by the reset pin so every output reads 0 while reset
  // is asserted and the readies come up immediately on deassertion.
  assign s_awready_o = arst_ni && (w_state_q == W_IDLE) && !aw_held_q;
  assign s_wready_o  = arst_ni && (w_state_q == W_IDLE) && !w_held_q;
  assign s_arready_o = arst_ni && (r_state_q == R_IDLE);

  assign aw_hs = s_awvalid_i && s_awready_o;
  assign w_hs  = s_wvalid_i  && s_wready_o;
  assign ar_hs = s_arvalid_i && s_arready_o;

  // -------------------------------------------------------------------------
  // Write FSM: collect AW and W in any order, issue once, hold B until taken
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) aw_held_d = 1'b1;
        if (w_hs)  w_held_d  = 1'b1;
        // Uses the updated flags so a same-cycle AW+W goes straight to EXEC.
        if (aw_held_d && w_held_d) w_state_d = W_EXEC;
      end
      W_EXEC: w_state_d = W_RESP;
      W_RESP: begin
        if (s_bready_i) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= 2'b00;
    end else begin
      if (aw_hs) waddr_q <= s_awaddr_i[ADDR_WIDTH-1:0];
      if (w_hs) begin
        wdata_q <= s_wdata_i;
        wstrb_q <= s_wstrb_i;
      end
      // The peripheral answers in the same cycle as mem_we_o.
      if (w_state_q == W_EXEC) bresp_q <= mem_wresp_i;
    end
  end

  assign mem_we_o    = (w_state_q == W_EXEC);
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign s_bvalid_o  = (w_state_q == W_RESP);
  assign s_bresp_o   = bresp_q;

  // -------------------------------------------------------------------------
  // Read FSM: one mem_re_o pulse per AR, data captured and held until taken
  // -------------------------------------------------------------------------
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_EXEC;
      R_EXEC:  r_state_d = R_RESP;
      R_RESP:  if (s_rready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state_q <= R_IDLE;
    end else begin
      r_state_q <= r_state_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      raddr_q <= '0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      if (ar_hs) raddr_q <= s_araddr_i[ADDR_WIDTH-1:0];
      // Captured once in EXEC, so back-pressure in RESP never re-reads.
      if (r_state_q == R_EXEC) begin
        rdata_q <= mem_rdata_i;
        rresp_q <= mem_rresp_i;
      end
    end
  end

  assign mem_re_o    = (r_state_q == R_EXEC);
  assign mem_raddr_o = raddr_q;
  assign s_rvalid_o  = (r_state_q == R_RESP);
  assign s_rdata_o   = rdata_q;
  assign s_rresp_o   = rresp_q;

endmodule

// File: tb/tb_axil_to_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_axil_to_mem_bridge
//
// Bench for axil_to_mem_bridge. A behavioural register file stands in for the
// peripheral. Stimulus tasks push expected memory beats and B/R responses into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_axil_to_mem_bridge;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [31:0] s_awaddr_i;
  logic        s_awvalid_i;
  logic        s_awready_o;
  logic [31:0] s_wdata_i;
  logic [3:0]  s_wstrb_i;
  logic        s_wvalid_i;
  logic        s_wready_o;
  logic [1:0]  s_bresp_o;
  logic        s_bvalid_o;
  logic        s_bready_i;
  logic [31:0] s_araddr_i;
  logic        s_arvalid_i;
  logic        s_arready_o;
  logic [31:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_rvalid_o;
  logic        s_rready_i;
  logic        mem_we_o;
  logic [5:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [1:0]  mem_wresp_i;
  logic        mem_re_o;
  logic [5:0]  mem_raddr_o;
  logic [31:0] mem_rdata_i;
  logic [1:0]  mem_rresp_i;

  axil_to_mem_bridge #(
    .AXI_ADDR_WIDTH(32),
    .ADDR_WIDTH    (6),
    .DATA_WIDTH    (32)
  ) dut (
    .arst_ni    (arst_ni),
    .clk_i      (clk_i),
    .s_awaddr_i (s_awaddr_i),
    .s_awvalid_i(s_awvalid_i),
    .s_awready_o(s_awready_o),
    .s_wdata_i  (s_wdata_i),
    .s_wstrb_i  (s_wstrb_i),
    .s_wvalid_i (s_wvalid_i),
    .s_wready_o (s_wready_o),
    .s_bresp_o  (s_bresp_o),
    .s_bvalid_o (s_bvalid_o),
    .s_bready_i (s_bready_i),
    .s_araddr_i (s_araddr_i),
    .s_arvalid_i(s_arvalid_i),
    .s_arready_o(s_arready_o),
    .s_rdata_o  (s_rdata_o),
    .s_rresp_o  (s_rresp_o),
    .s_rvalid_o (s_rvalid_o),
    .s_rready_i (s_rready_i),
    .mem_we_o   (mem_we_o),
    .mem_waddr_o(mem_waddr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_wresp_i(mem_wresp_i),
    .mem_re_o   (mem_re_o),
    .mem_raddr_o(mem_raddr_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_rresp_i(mem_rresp_i)
  );

  always #5 clk_i = ~clk_i;

  // Peripheral stand-in (responds combinationally) and reference contents
  logic [31:0] periph    [64];
  logic [31:0] model     [64];
  logic [1:0]  rresp_tab [64];
  logic [1:0]  wresp_tab [64];

  assign mem_rdata_i = periph[mem_raddr_o];
  assign mem_rresp_i = rresp_tab[mem_raddr_o];
  assign mem_wresp_i = wresp_tab[mem_waddr_o];

  logic [41:0] wbeat_q [$];
  logic [1:0]  bexp_q  [$];
  logic [33:0] rexp_q  [$];

  int checks = 0;
  int failures = 0;
  int we_cnt = 0, re_cnt = 0, n_wr = 0, n_rd = 0;
  int cyc = 0, last_we_cyc = -1, last_re_cyc = -2;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic        b_wait, r_wait;
    logic [1:0]  prev_b;
    logic [33:0] prev_r;
    logic [41:0] eb;
    logic [1:0]  ebr;
    logic [33:0] er;
    b_wait = 1'b0;
    r_wait = 1'b0;
    prev_b = 2'b00;
    prev_r = '0;
    forever begin
      @(negedge clk_i);
      if (!arst_ni) begin
        b_wait = 1'b0;
        r_wait = 1'b0;
      end else begin
        if (mem_we_o) begin
          we_cnt++;
          last_we_cyc = cyc;
          if (wbeat_q.size() == 0) check("we_unexpected", mem_we_o, 1'b0);
          else begin
            eb = wbeat_q.pop_front();
            check("mem_wbeat", {mem_waddr_o, mem_wdata_o, mem_wstrb_o}, eb);
          end
          for (int i = 0; i < 4; i++)
            if (mem_wstrb_o[i]) periph[mem_waddr_o][8*i +: 8] = mem_wdata_o[8*i +: 8];
        end
        if (mem_re_o) begin
          re_cnt++;
          last_re_cyc = cyc;
        end
        if (b_wait) check("b_stable", {s_bvalid_o, s_bresp_o}, {1'b1, prev_b});
        if (s_bvalid_o && s_bready_i) begin
          if (bexp_q.size() == 0) check("b_unexpected", s_bvalid_o, 1'b0);
          else begin
            ebr = bexp_q.pop_front();
            check("bresp", s_bresp_o, ebr);
          end
        end
        b_wait = s_bvalid_o && !s_bready_i;
        prev_b = s_bresp_o;
        if (r_wait) check("r_stable", {s_rvalid_o, s_rresp_o, s_rdata_o}, {1'b1, prev_r});
        if (s_rvalid_o && s_rready_i) begin
          if (rexp_q.size() == 0) check("r_unexpected", s_rvalid_o, 1'b0);
          else begin
            er = rexp_q.pop_front();
            check("rdata_rresp", {s_rdata_o, s_rresp_o}, er);
          end
        end
        r_wait = s_rvalid_o && !s_rready_i;
        prev_r = {s_rresp_o, s_rdata_o};
      end
    end
  end

  // Handshake helpers: start and end at posedge+1
  task automatic aw_hs(input logic [31:0] a);
    int n = 0;
    s_awaddr_i = a;
    s_awvalid_i = 1'b1;
    @(negedge clk_i);
    while (!s_awready_o && n < 50) begin n++; @(negedge clk_i); end
    check("awready", s_awready_o, 1'b1);
    @(posedge clk_i); #1;
    s_awvalid_i = 1'b0;
  endtask

  task automatic w_hs(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_wdata_i = d;
    s_wstrb_i = s;
    s_wvalid_i = 1'b1;
    @(negedge clk_i);
    while (!s_wready_o && n < 50) begin n++; @(negedge clk_i); end
    check("wready", s_wready_o, 1'b1);
    @(posedge clk_i); #1;
    s_wvalid_i = 1'b0;
  endtask

  task automatic aww_hs(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_awaddr_i = a; s_wdata_i = d; s_wstrb_i = s;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
    @(negedge clk_i);
    while (!(s_awready_o && s_wready_o) && n < 50) begin n++; @(negedge clk_i); end
    check("aw_w_ready", {s_awready_o, s_wready_o}, 2'b11);
    @(posedge clk_i); #1;
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
  endtask

  // lead > 0: W precedes AW by lead cycles; lead < 0: AW precedes W
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int stall);
    logic [5:0] ai;
    int we0;
    ai = a[5:0];
    wbeat_q.push_back({ai, d, s});
    bexp_q.push_back(wresp_tab[ai]);
    for (int i = 0; i < 4; i++) if (s[i]) model[ai][8*i +: 8] = d[8*i +: 8];
    n_wr++;
    we0 = we_cnt;
    if (lead == 0) begin
      aww_hs(a, d, s);
    end else if (lead > 0) begin
      w_hs(d, s);
      check("wready_drop", s_wready_o, 1'b0);
      repeat (lead - 1) begin @(posedge clk_i); #1; end
      aw_hs(a);
    end else begin
      aw_hs(a);
      check("awready_drop", s_awready_o, 1'b0);
      repeat (-lead - 1) begin @(posedge clk_i); #1; end
      w_hs(d, s);
    end
    check("no_early_we", we_cnt, we0);
    check("we_pulse", {mem_we_o, mem_waddr_o}, {1'b1, ai});
    @(posedge clk_i); #1;
    check("b_latency", {mem_we_o, s_bvalid_o}, 2'b01);
    repeat (stall) begin @(posedge clk_i); #1; end
    s_bready_i = 1'b1;
    @(negedge clk_i);
    check("bvalid_hold", s_bvalid_o, 1'b1);
    @(posedge clk_i); #1;
    s_bready_i = 1'b0;
    check("w_ready_back", {s_bvalid_o, s_awready_o, s_wready_o}, 3'b011);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall);
    logic [5:0] ai;
    int n = 0;
    ai = a[5:0];
    rexp_q.push_back({model[ai], rresp_tab[ai]});
    n_rd++;
    s_araddr_i = a;
    s_arvalid_i = 1'b1;
    @(negedge clk_i);
    while (!s_arready_o && n < 50) begin n++; @(negedge clk_i); end
    check("arready", s_arready_o, 1'b1);
    @(posedge clk_i); #1;
    s_arvalid_i = 1'b0;
    check("re_pulse", {mem_re_o, mem_raddr_o}, {1'b1, ai});
    @(posedge clk_i); #1;
    check("r_latency", {mem_re_o, s_rvalid_o}, 2'b01);
    repeat (stall) begin @(posedge clk_i); #1; end
    s_rready_i = 1'b1;
    @(negedge clk_i);
    check("rvalid_hold", s_rvalid_o, 1'b1);
    @(posedge clk_i); #1;
    s_rready_i = 1'b0;
    check("r_ready_back", {s_rvalid_o, s_arready_o}, 2'b01);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int we0;
    arst_ni = 1'b0;
    s_awaddr_i = '0; s_awvalid_i = 1'b0;
    s_wdata_i = '0;  s_wstrb_i = '0; s_wvalid_i = 1'b0;
    s_bready_i = 1'b0;
    s_araddr_i = '0; s_arvalid_i = 1'b0;
    s_rready_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      periph[i]    = $urandom;
      model[i]     = periph[i];
      rresp_tab[i] = 2'($urandom_range(0, 3));
      wresp_tab[i] = 2'($urandom_range(0, 3));
    end
    wresp_tab[6'h14] = 2'b00;
    wresp_tab[6'h04] = 2'b00;
    periph[6'h20] = 32'hA5; model[6'h20] = 32'hA5; rresp_tab[6'h20] = 2'b00;
    wresp_tab[6'h30] = 2'b10; rresp_tab[6'h30] = 2'b10;
    wresp_tab[6'h08] = 2'b00; rresp_tab[6'h0C] = 2'b00;

    // Reset state
    #12;
    check("reset_outputs",
          {s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o, mem_we_o, mem_re_o},
          7'b0);
    check("reset_data", {s_bresp_o, s_rresp_o, s_rdata_o, mem_waddr_o, mem_wdata_o}, '0);
    @(posedge clk_i); #2;
    arst_ni = 1'b1;
    #1;
    check("readies_after_reset", {s_awready_o, s_wready_o, s_arready_o}, 3'b111);
    @(posedge clk_i); #1;

    // Same-cycle AW+W, upper address bits dropped
    do_write(32'h1000_0014, 32'h0000_0041, 4'hF, 0, 0);
    // W three cycles before AW
    do_write(32'h0000_0004, 32'h1234_5678, 4'hF, 3, 1);
    // AW before W, partial strobes
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'b0101, -2, 2);
    // Read with R back-pressure
    do_read(32'h0000_0020, 5);
    do_read(32'h0000_0010, 0);
    // Error responses forwarded
    do_write(32'h0000_0030, 32'h0BAD_F00D, 4'hF, 0, 0);
    do_read(32'h0000_0030, 1);

    // Concurrent write and read in the same cycle
    fork
      do_write(32'h0000_0008, 32'hCAFE_0008, 4'hF, 0, 1);
      do_read(32'h0000_000C, 2);
    join
    check("we_re_same_cycle", last_we_cyc, last_re_cyc);

    // Reset while in W_RESP aborts the response
    aww_hs(32'h0000_0018, 32'h5555_AAAA, 4'hF);
    wbeat_q.push_back({6'h18, 32'h5555_AAAA, 4'hF});
    bexp_q.push_back(wresp_tab[6'h18]);
    model[6'h18] = 32'h5555_AAAA;
    n_wr++;
    @(posedge clk_i); #1;
    check("abort_in_resp", s_bvalid_o, 1'b1);
    #3;
    arst_ni = 1'b0;
    #1;
    check("abort_bvalid_low", {s_bvalid_o, s_bresp_o, mem_we_o}, 4'b0);
    void'(bexp_q.pop_front());
    we0 = we_cnt;
    @(posedge clk_i); #2;
    arst_ni = 1'b1;
    #1;
    check("abort_readies", {s_awready_o, s_wready_o, s_arready_o}, 3'b111);
    repeat (4) @(posedge clk_i);
    #1;
    check("abort_no_we", {we_cnt, 1'b0, s_bvalid_o}, {we0, 1'b0, 1'b0});
    do_read(32'h0000_0018, 0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      int          op, lead, st;
      a    = $urandom;
      d    = $urandom;
      s    = 4'($urandom_range(0, 15));
      op   = $urandom_range(0, 2);
      lead = $urandom_range(0, 6) - 3;
      st   = $urandom_range(0, 3);
      if (op == 0) do_write(a, d, s, lead, st);
      else if (op == 1) do_read(a, st);
      else begin
        fork
          do_write(a, d, s, lead, st);
          do_read({a[31:6], a[5:0] ^ 6'h01}, 3 - st);
        join
      end
    end

    repeat (3) @(posedge clk_i);
    #1;
    check("queues_drained", {32'(wbeat_q.size()), 16'(bexp_q.size()), 16'(rexp_q.size())}, 64'd0);
    check("we_count", we_cnt, n_wr);
    check("re_count", re_cnt, n_rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axil_to_mem_bridge.md
Name: axil_to_mem_bridge

Overview:
- AXI4-Lite subordinate to simple memory-interface initiator bridge; it drives the mem_we/mem_waddr/mem_re/mem_raddr interface that UART and other peripheral register blocks expose.
- Sits between the SoC AXI4-Lite crossbar and one peripheral register interface.
- Write and read paths are independent FSMs and may issue to the memory side in the same cycle.
- The memory side responds combinationally in the same cycle as mem_we_o / mem_re_o.

Parameters:
- AXI_ADDR_WIDTH, 32, width of AXI AWADDR/ARADDR.
- ADDR_WIDTH, 6, width of the memory-side address; the bridge truncates AXI addresses to the low ADDR_WIDTH bits.
- DATA_WIDTH, 32, data width on both sides; must be a multiple of 8.

Ports:
- arst_ni  in  1  asynchronous active-low reset
- clk_i  in  1  clock
- s_awaddr_i  in  AXI_ADDR_WIDTH  write address
- s_awvalid_i  in  1  write address valid
- s_awready_o  out  1  write address ready
- s_wdata_i  in  DATA_WIDTH  write data
- s_wstrb_i  in  DATA_WIDTH/8  write strobes
- s_wvalid_i  in  1  write data valid
- s_wready_o  out  1  write data ready
- s_bresp_o  out  2  write response
- s_bvalid_o  out  1  write response valid
- s_bready_i  in  1  write response ready
- s_araddr_i  in  AXI_ADDR_WIDTH  read address
- s_arvalid_i  in  1  read address valid
- s_arready_o  out  1  read address ready
- s_rdata_o  out  DATA_WIDTH  read data
- s_rresp_o  out  2  read response
- s_rvalid_o  out  1  read valid
- s_rready_i  in  1  read ready
- mem_we_o  out  1  write enable
- mem_waddr_o  out  ADDR_WIDTH  write address
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_wstrb_o  out  DATA_WIDTH/8  write strobes
- mem_wresp_i  in  2  write response (00 OKAY, 10 SLVERR)
- mem_re_o  out  1  read enable
- mem_raddr_o  out  ADDR_WIDTH  read address
- mem_rdata_i  in  DATA_WIDTH  read data
- mem_rresp_i  in  2  read response

Behaviour:
- Reset (arst_ni low, asynchronous):
  - Write FSM to W_IDLE; read FSM to R_IDLE.
  - All outputs 0, except s_awready_o=1, s_wready_o=1, s_arready_o=1 as soon as reset deasserts.
  - Internal address/data/strobe holding registers cleared.
- Write FSM W_IDLE:
  - s_awready_o = !aw_held; s_wready_o = !w_held.
  - AW handshake latches awaddr[ADDR_WIDTH-1:0] and sets aw_held.
  - W handshake latches wdata and wstrb and sets w_held.
  - AW and W may arrive in the same cycle or in either order with any gap.
  - When both are held (including both captured in the same cycle), go to W_EXEC next cycle.
- Write FSM W_EXEC (exactly 1 cycle):
  - mem_we_o=1; mem_waddr_o/mem_wdata_o/mem_wstrb_o driven from holding registers.
  - s_bresp_o registered from mem_wresp_i; go to W_RESP.
- Write FSM W_RESP:
  - s_bvalid_o=1; s_bresp_o held stable until s_bready_i.
  - On handshake: clear aw_held/w_held, return to W_IDLE; readies reassert the next cycle.
- Write latency and throughput:
  - Best-case latency is AW+W handshake cycle -> mem_we_o next cycle -> s_bvalid_o the following cycle.
  - Throughput is one write per 3 cycles minimum.
- Read FSM R_IDLE:
  - s_arready_o=1.
  - AR handshake latches araddr[ADDR_WIDTH-1:0]; go to R_EXEC.
- Read FSM R_EXEC (exactly 1 cycle):
  - mem_re_o=1, mem_raddr_o from holding register.
  - s_rdata_o and s_rresp_o registered from mem_rdata_i and mem_rresp_i; go to R_RESP.
- Read FSM R_RESP:
  - s_rvalid_o=1, data and response stable until s_rready_i; then go to R_IDLE.
- mem_we_o and mem_re_o each pulse exactly one cycle per AXI transaction.
  - This is mandatory: reads of destructive registers (FIFO pop) must occur exactly once.
  - A read held in R_RESP under backpressure never re-asserts mem_re_o.
- Outside EXEC states, mem_w*/mem_raddr outputs hold the last latched values; only the enables gate activity.
- Upper address bits above ADDR_WIDTH are ignored; no decode error is generated by the bridge.
- Responses are forwarded unmodified, including 2'b01 and 2'b11.
- Write and read paths run concurrently; same-cycle mem_we_o and mem_re_o to the same address is legal and passed through.
- Reset mid-transaction aborts it: any held beat is discarded, no B/R response is produced, and readies return to 1.

Test Plan:
- AW (addr 0x1000_0014) and W (data 0x41, strb 0xF) in the same cycle:
  - next cycle mem_we_o=1, mem_waddr_o=0x14, mem_wdata_o=0x41.
  - mem_wresp_i=00 -> s_bvalid_o=1, s_bresp_o=00 the cycle after.
- W three cycles before AW:
  - s_wready_o drops after the W handshake; no mem_we_o until AW arrives.
  - mem_we_o fires exactly once, the cycle after AW.
- Read addr 0x20 with mem_rdata_i=0xA5, mem_rresp_i=00, s_rready_i held low 5 cycles:
  - mem_re_o high exactly 1 cycle.
  - s_rdata_o=0xA5 stable, s_rvalid_o stays high until s_rready_i.
- Read with mem_rresp_i=10 -> s_rresp_o=10; write with mem_wresp_i=10 -> s_bresp_o=10.
- Concurrent write to 0x08 and read from 0x0C issued in the same cycle:
  - mem_we_o and mem_re_o assert in the same cycle.
  - Both responses are returned correctly.
- arst_ni pulsed low while in W_RESP:
  - s_bvalid_o=0 immediately, all readies=1 after deassertion.
  - No mem_we_o is issued afterwards for the aborted beat.
